// File: rtl/power_aes_pkg.sv
// Shared constants, FSM encoding and AES byte-level helpers for the power-analysis target.
package power_aes_pkg;

    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } fsm_state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[(11'd2047 - {x, 3'b000}) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/power_aes_if.sv
// Start/done handshake between the sequencing FSM and the AES core.
interface power_aes_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic         done;

    modport master (output start, output key, output pt, input ct, input done);
    modport slave  (input start, input key, input pt, output ct, output done);
endinterface

// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryption: one round per cycle with on-the-fly key expansion.
module aes128_enc_core
    import power_aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] pt,
    output logic [127:0] ct,
    output logic         done
);

    logic [127:0] r_state;
    logic [127:0] r_rkey;
    logic [127:0] r_ct;
    logic [3:0]   r_round;
    logic         r_busy;
    logic         r_done;

    logic [127:0] w_sub_shift;
    logic [127:0] w_mix;
    logic [127:0] w_next_rkey;
    logic [127:0] w_round_out;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub_word;
    logic [31:0]  w_key_tmp;

    genvar gi;

    // SubBytes fused with ShiftRows: byte (row, col) comes from column (col + row) mod 4.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_subshift
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
            assign w_sub_shift[127-8*gi -: 8] = sbox(r_state[127-8*SRC -: 8]);
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_sub_shift[127-32*gi -: 8];
            assign w_a1 = w_sub_shift[119-32*gi -: 8];
            assign w_a2 = w_sub_shift[111-32*gi -: 8];
            assign w_a3 = w_sub_shift[103-32*gi -: 8];
            assign w_mix[127-32*gi -: 32] = {
                xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
                w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
                w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
                xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
            };
        end

        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            assign w_sub_word[31-8*gi -: 8] = sbox(w_rot[31-8*gi -: 8]);
        end
    endgenerate

    assign w_rot       = {r_rkey[23:0], r_rkey[31:24]};
    assign w_key_tmp   = w_sub_word ^ {rcon(r_round), 24'h000000};
    assign w_next_rkey[127:96] = r_rkey[127:96] ^ w_key_tmp;
    assign w_next_rkey[95:64]  = r_rkey[95:64]  ^ w_next_rkey[127:96];
    assign w_next_rkey[63:32]  = r_rkey[63:32]  ^ w_next_rkey[95:64];
    assign w_next_rkey[31:0]   = r_rkey[31:0]   ^ w_next_rkey[63:32];

    // The final round skips MixColumns.
    assign w_round_out = ((r_round == 4'd10) ? w_sub_shift : w_mix) ^ w_next_rkey;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= '0;
            r_rkey  <= '0;
            r_ct    <= '0;
            r_round <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_state <= pt ^ key;
                r_rkey  <= key;
                r_round <= 4'd1;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_state <= w_round_out;
                r_rkey  <= w_next_rkey;
                r_round <= r_round + 4'd1;
                if (r_round == 4'd10) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_ct   <= w_round_out;
                end
            end
        end
    end

    assign ct   = r_ct;
    assign done = r_done;

endmodule

// File: rtl/power_aes_top.sv
// AES-128 power-analysis target: known-answer check, then endless ciphertext chaining.
module power_aes_top
    import power_aes_pkg::*;
#(
    parameter int HB_BIT = 23
)
(
    input  logic ICE_CLK,
    input  logic RST_N,
    output logic ICE_LED,
    output logic RGB_R,
    output logic RGB_G,
    output logic RGB_B
);

    fsm_state_t   r_state;
    logic         r_start;
    logic [127:0] r_pt;
    logic [127:0] r_ct;
    logic [31:0]  r_enc_cnt;
    logic [31:0]  r_cyc_cnt;
    logic         r_pass;
    logic         r_fail;
    logic         r_blue;

    logic [127:0] w_ct;
    logic         w_done;
    logic         w_unused_cyc;

    power_aes_if u_core_if ();

    assign u_core_if.start = r_start;
    assign u_core_if.key   = K;
    assign u_core_if.pt    = r_pt;
    assign w_ct            = u_core_if.ct;
    assign w_done          = u_core_if.done;

    aes128_enc_core u_core (
        .clk   (ICE_CLK),
        .rst_n (RST_N),
        .start (u_core_if.start),
        .key   (u_core_if.key),
        .pt    (u_core_if.pt),
        .ct    (u_core_if.ct),
        .done  (u_core_if.done)
    );

    // start is raised on entry to ST_START so it is high exactly for that cycle.
    always_ff @(posedge ICE_CLK) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_pt      <= P0;
            r_ct      <= '0;
            r_enc_cnt <= '0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_blue    <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_START;
                    r_start <= 1'b1;
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_ct    <= w_ct;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Verdict is taken once; a wrapped enc_cnt must not re-judge.
                    if (r_enc_cnt == 32'd0 && !r_pass && !r_fail) begin
                        r_pass <= (r_ct == C0);
                        r_fail <= (r_ct != C0);
                    end
                    r_pt      <= r_ct;
                    r_enc_cnt <= r_enc_cnt + 32'd1;
                    r_blue    <= ~r_blue;
                    r_state   <= ST_START;
                    r_start   <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ICE_CLK) begin
        if (!RST_N) begin
            r_cyc_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
        end
    end

    assign w_unused_cyc = ^r_cyc_cnt;

    assign ICE_LED = r_cyc_cnt[HB_BIT];
    assign RGB_G   = r_pass;
    assign RGB_R   = r_fail;
    assign RGB_B   = r_blue;

endmodule

// File: tb/tb_power_aes_top.sv
// Randomized reset/fault scenarios with a queue scoreboard fed by a byte-level AES reference model.
module tb_power_aes_top;
    import power_aes_pkg::*;

    localparam logic [127:0] BAD_CT = 128'hdeadbeef0badf00d1234567890abcdef;

    logic clk;
    logic rst_n;
    logic led_a, r_a, g_a, b_a;
    logic led_b, r_b, g_b, b_b;

    power_aes_top dut (
        .ICE_CLK (clk),
        .RST_N   (rst_n),
        .ICE_LED (led_a),
        .RGB_R   (r_a),
        .RGB_G   (g_a),
        .RGB_B   (b_a)
    );

    power_aes_top #(.HB_BIT(3)) dut_hb (
        .ICE_CLK (clk),
        .RST_N   (rst_n),
        .ICE_LED (led_b),
        .RGB_R   (r_b),
        .RGB_G   (g_b),
        .RGB_B   (b_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_edges  = 0;
    int n_done   = 0;
    bit fault_mode = 1'b0;
    logic rst_q  = 1'b0;
    logic rst_q2 = 1'b0;
    logic [31:0] hb_cnt = '0;
    logic [127:0] exp_pt_q[$];
    logic [127:0] exp_ct_q[$];
    logic [7:0] sbox_m[256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, r;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv;
            for (int k = 0; k < 4; k++) begin
                inv = rotl1(inv);
                r = r ^ inv;
            end
            sbox_m[x] = r ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] st[16];
        logic [7:0] t[16];
        logic [7:0] rk[176];
        logic [7:0] tmp[4];
        logic [7:0] rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            st[i] = pt[127-8*i -: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int w = 4; w < 44; w++) begin
            for (int j = 0; j < 4; j++) tmp[j] = rk[4*(w-1)+j];
            if (w % 4 == 0) begin
                logic [7:0] t0;
                t0 = tmp[0];
                tmp[0] = sbox_m[tmp[1]] ^ rc;
                tmp[1] = sbox_m[tmp[2]];
                tmp[2] = sbox_m[tmp[3]];
                tmp[3] = sbox_m[t0];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) rk[4*w+j] = rk[4*(w-4)+j] ^ tmp[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sbox_m[st[4*((c+row)%4)+row]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    st[4*c+0] = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    st[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    st[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    st[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int row = 0; row < 4; row++) st[4*c+row] = t[4*c+row];
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // Expected chain for one reset episode: pt[0]=P0, ct[0]=C0 (or injected), pt[i+1]=ct[i].
    task automatic load_expected(input bit fault);
        logic [127:0] pt, ct;
        exp_pt_q.delete();
        exp_ct_q.delete();
        pt = P0;
        for (int i = 0; i < 40; i++) begin
            exp_pt_q.push_back(pt);
            if (i == 0) ct = fault ? BAD_CT : C0;
            else        ct = aes_ref(K, pt);
            exp_ct_q.push_back(ct);
            pt = ct;
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        n_edges <= n_edges + 1;
        rst_q   <= rst_n;
        rst_q2  <= rst_q;
        hb_cnt  <= rst_n ? hb_cnt + 32'd1 : 32'd0;
    end

    always @(negedge clk) begin
        if (n_edges > 0) begin
            if (!rst_q) begin
                check("reset_outputs", {r_a, g_a, b_a, led_a}, 4'b0000);
                check("reset_outputs_hb", {r_b, g_b, b_b, led_b}, 4'b0000);
                check("reset_state_idle", dut.r_state, ST_IDLE);
                n_done = 0;
            end else begin
                if (!rst_q2) check("state_after_release", dut.r_state, ST_START);
                if (dut.r_start) begin
                    if (exp_pt_q.size() == 0) begin
                        check("start_pt_queue_empty", 1'b1, 1'b0);
                    end else begin
                        check("start_pt", dut.r_pt, exp_pt_q.pop_front());
                    end
                    check("blue_parity", b_a, n_done[0]);
                    if (n_done > 0) begin
                        check("green_led", g_a, !fault_mode);
                        check("red_led", r_a, fault_mode);
                    end
                end
                if (dut.w_done) begin
                    if (exp_ct_q.size() == 0) begin
                        check("done_ct_queue_empty", 1'b1, 1'b0);
                    end else begin
                        logic [127:0] exp_ct;
                        exp_ct = exp_ct_q.pop_front();
                        check("done_ct", dut.w_ct, exp_ct);
                        $display("enc %0d: ct=%h expected=%h", n_done, dut.w_ct, exp_ct);
                    end
                    n_done++;
                end
            end
            check("heartbeat_hb3", led_b, hb_cnt[3]);
            check("heartbeat_hb23", led_a, hb_cnt[23]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic inject_fault();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 70 && !found; c++) begin
            @(posedge clk); #2;
            if (dut.w_done) begin
                force dut.w_ct = BAD_CT;
                found = 1'b1;
            end
        end
        check("fault_done_seen", found, 1'b1);
        if (found) begin
            @(posedge clk); #1;
            release dut.w_ct;
        end
    endtask

    task automatic wait_for_led();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 70 && !seen; c++) begin
            @(negedge clk);
            if (g_a || r_a) seen = 1'b1;
        end
        check("verdict_within_70", seen, 1'b1);
        check("verdict_green", g_a, !fault_mode);
        check("verdict_red", r_a, fault_mode);
    endtask

    task automatic reset_in_wait();
        bit found;
        found = 1'b0;
        repeat ($urandom_range(20, 150)) @(posedge clk);
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (dut.r_state == ST_START) found = 1'b1;
        end
        check("reached_start_before_wait", found, 1'b1);
        @(posedge clk); #1;
        repeat ($urandom_range(0, 8)) @(posedge clk);
        #0;
        check("reset_taken_in_wait", dut.r_state, ST_WAIT);
        $display("reset asserted during WAIT at %0t", $time);
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        build_sbox();
        for (int ep = 0; ep < 6; ep++) begin
            int hold;
            hold = (ep == 0) ? 10 : int'($urandom_range(2, 6));
            repeat (hold - 1) @(posedge clk);
            fault_mode = (ep == 2);
            load_expected(fault_mode);
            @(posedge clk); #1;
            rst_n = 1'b1;
            $display("episode %0d released (fault=%0d)", ep, fault_mode);
            if (fault_mode) inject_fault();
            wait_for_led();
            if (ep == 1 || ep == 4 || $urandom_range(0, 1) == 1) begin
                reset_in_wait();
            end else begin
                repeat ($urandom_range(60, 300)) @(posedge clk);
                #1;
                rst_n = 1'b0;
            end
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
